transmissor_jogada: RTL

- Serializes one accepted move (current player, macro cell, micro cell) into a two-byte asynchronous serial packet (8N1, LSB first) for a remote opponent board.
- Sits beside the game circuit: the control unit pulses `partida` when a move is registered; the block drives `saida_serial`.
- Reports busy/done to the control unit so it can hold further moves until transmission ends.
- Counterpart of the move-receiving path: it emits moves instead of accepting them.

---
 rtl/transmissor_jogada.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/transmissor_jogada.sv
// transmissor_jogada: serializes one game move as two 8N1 bytes,
// LSB first, with busy/done/reject reporting to the control unit.
module transmissor_jogada #(
  parameter int CLKS_POR_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       jogador,
  input  logic [3:0] macro,
  input  logic [3:0] micro,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int W = $clog2(CLKS_POR_BIT);
  localparam logic [W-1:0] CNT_MAX = W'(CLKS_POR_BIT - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    START   = 4'd2,
    DADOS   = 4'd3,
    STOP    = 4'd4,
    PROXIMO = 4'd5,
    FIM     = 4'd6,
    REJEITA = 4'd14
  } estado_t;

  estado_t r_estado;
  estado_t w_prox;

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_prox;
  logic [2:0]   r_idx;
  logic         r_sel;
  logic [7:0]   r_byte0;
  logic [7:0]   r_byte1;
  logic         r_linha;

  logic         w_fim_bit;
  logic         w_valido;
  logic         w_paridade;
  logic [7:0]   w_byte0;
  logic [7:0]   w_byte1;
  logic [7:0]   w_byte_atual;
  logic         w_bit;

  assign w_fim_bit    = (r_cnt == CNT_MAX);
  assign w_cnt_prox   = w_fim_bit ? '0 : r_cnt + W'(1);
  assign w_valido     = (macro <= 4'd8) && (micro <= 4'd8);
  assign w_paridade   = ^{jogador, macro, micro};
  assign w_byte0      = {3'b110, jogador, macro};
  assign w_byte1      = {3'b011, w_paridade, micro};
  assign w_byte_atual = r_sel ? r_byte1 : r_byte0;
  assign w_bit        = w_byte_atual[r_idx];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic; the byte0->byte1 hand-off skips straight to START
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      OCIOSO: begin
        if (partida) begin
          w_prox = w_valido ? CARREGA : REJEITA;
        end
      end
      CARREGA: w_prox = START;
      START: begin
        if (w_fim_bit) begin
          w_prox = DADOS;
        end
      end
      DADOS: begin
        if (w_fim_bit && (r_idx == 3'd7)) begin
          w_prox = STOP;
        end
      end
      STOP: begin
        if (w_fim_bit) begin
          w_prox = r_sel ? FIM : START;
        end
      end
      FIM:     w_prox = OCIOSO;
      REJEITA: w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    ocupado   = 1'b0;
    pronto    = 1'b0;
    erro      = 1'b0;
    db_estado = r_estado;
    unique case (r_estado)
      CARREGA, START, DADOS, STOP: ocupado = 1'b1;
      FIM:     pronto = 1'b1;
      REJEITA: erro = 1'b1;
      default: ;
    endcase
  end

  // Bit timer, bit index, byte select and the latched packet bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sel   <= 1'b0;
      r_byte0 <= '0;
      r_byte1 <= '0;
    end else begin
      unique case (r_estado)
        CARREGA: begin
          r_byte0 <= w_byte0;
          r_byte1 <= w_byte1;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_sel   <= 1'b0;
        end
        START: r_cnt <= w_cnt_prox;
        DADOS: begin
          r_cnt <= w_cnt_prox;
          if (w_fim_bit) begin
            r_idx <= r_idx + 3'd1;
          end
        end
        STOP: begin
          r_cnt <= w_cnt_prox;
          if (w_fim_bit) begin
            r_sel <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Registered serial line, one cycle behind the state it reflects
  always_ff @(posedge clock) begin
    if (reset) begin
      r_linha <= 1'b1;
    end else begin
      unique case (r_estado)
        START:   r_linha <= 1'b0;
        DADOS:   r_linha <= w_bit;
        default: r_linha <= 1'b1;
      endcase
    end
  end

  assign saida_serial = r_linha;

endmodule
